nor3_x2: RTL and testbench
==========================

# nor3_x2

Three-input NOR cell, drive strength X2, for the gate-level standard-cell library. Core function: output ZN is the combinational NOR of A1, A2, A3. A clocked observation wrapper around the gate adds a registered copy of ZN and saturating rise/fall activity counters, which feed power and activity characterization in the library regression. Plain logic use takes only the combinational path.

## Interface
Parameters:
- CNT_W, default 16: width of each activity counter.

Ports:
- clk  input  1  observation clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset for all observation state.
- A1  input  1  NOR input 1.
- A2  input  1  NOR input 2.
- A3  input  1  NOR input 3.
- ZN  output  1  combinational ~(A1 | A2 | A3).
- ZN_q  output  1  ZN registered on clk.
- rise_cnt  output  CNT_W  count of sampled 0->1 transitions of ZN.
- fall_cnt  output  CNT_W  count of sampled 1->0 transitions of ZN.
- cnt_sat  output  1  high while either counter is at all-ones.

Declaration order:
- Ports are declared in the order A1, A2, A3, ZN, clk, rst, ZN_q, rise_cnt, fall_cnt, cnt_sat.
- A four-port positional hookup (A1, A2, A3, ZN) must therefore bind correctly.

## Operation
- ZN = ~(A1 | A2 | A3), purely combinational.
- ZN is independent of clk, rst and all state, and stays correct when clk and rst are unconnected.
- Truth table in A1 A2 A3 order: 000->1; every other combination (001 through 111) ->0.
- X or Z on any input gives X on ZN, except when another input is 1; in that case ZN is 0.
- ZN_q: captures ZN on each rising clk edge.
- prev: an internal register holding the previous sampled ZN.
- rise_cnt: increments when ZN = 1 and prev = 0. It saturates at 2^CNT_W-1 and never wraps.
- fall_cnt: increments when ZN = 0 and prev = 1. It saturates the same way.
- Rise and fall cannot both occur in one cycle. Multiple ZN glitches between two edges count as at most one sampled transition.
- cnt_sat = (rise_cnt == all-ones) | (fall_cnt == all-ones). It is combinational from the counter registers.

## Timing
- ZN follows inputs with zero cycle latency. It must settle within 1 time unit; there are no registered stages on this path.
- ZN_q lags ZN by exactly one rising clk edge.
- Counters update on the same edge that samples the transition. The new count is visible after that edge.
- Reset values, applied immediately on rst assertion regardless of clk:
  - ZN_q = 0
  - prev = 1 (this matches ZN for all-zero inputs)
  - rise_cnt = 0
  - fall_cnt = 0
  - cnt_sat = 0
- rst asserted mid-operation: all observation state returns to its reset values at once, and ZN is unaffected.
- First edge after rst deasserts: compares ZN against prev = 1. If inputs are 000, nothing is counted. Otherwise fall_cnt becomes 1.

## Structure
- Shared package for the cell library holds:
  - the default CNT_W constant;
  - a drive-strength enum (X1/X2/X4), so sibling cells NOR3_X1 and NOR3_X4 share the wrapper.
- One sub-module, activity_mon: owns ZN_q, prev, both counters and cnt_sat, parameterized by CNT_W.
- nor3_x2 itself holds only the combinational NOR and the activity_mon instance.

## Test plan
- Walk inputs 000,001,010,011,100,101,110,111, holding each for 10 time units. ZN must be 1,0,0,0,0,0,0,0 respectively, with clk and rst left unconnected.
- Reset with inputs 000, then switch to 100 and give one clk edge:
  - ZN_q = 0
  - fall_cnt = 1
  - rise_cnt = 0
- Toggle inputs 000 and 001 alternately for 10 edges, starting from 000 after reset. Final state: rise_cnt = 5, fall_cnt = 5, and ZN_q tracks ZN one edge late.
- Set CNT_W = 2 and toggle for 8 transitions:
  - both counters stop at 3;
  - cnt_sat rises on the edge where the first counter reaches 3;
  - there is no wrap.
- Assert rst asynchronously between clk edges with counters nonzero. All counters and ZN_q clear immediately, and ZN keeps following inputs.
- Drive A1 = 1 with A2 = X. ZN must be 0, not X.

Source files
------------

// File: rtl/nor3_x2_pkg.sv
// Shared definitions for the NOR3 cell family.
// Holds the default counter width and the drive-strength enum.
package nor3_x2_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    DRIVE_X1 = 2'd0,
    DRIVE_X2 = 2'd1,
    DRIVE_X4 = 2'd2
  } drive_e;

endpackage

// File: rtl/nor3_x2_activity_mon.sv
// Activity monitor: registered copy of a cell output plus
// saturating rise/fall counters.
// Ports: clk, rst (async, active-high), zn (observed net),
//   zn_q (zn registered), rise_cnt, fall_cnt, cnt_sat.
`timescale 1ns/1ps
module activity_mon
  import nor3_x2_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zn,
  output logic             zn_q,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic prev;
  logic rise;
  logic fall;
  logic rise_full;
  logic fall_full;

  assign rise      = zn & ~prev;
  assign fall      = ~zn & prev;
  assign rise_full = (rise_cnt == ONES);
  assign fall_full = (fall_cnt == ONES);
  assign cnt_sat   = rise_full | fall_full;

  // prev resets high so all-zero inputs after reset are
  // not mistaken for a transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zn_q <= 1'b0;
      prev <= 1'b1;
    end else begin
      zn_q <= zn;
      prev <= zn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_cnt <= '0;
    end else if (rise && !rise_full) begin
      rise_cnt <= rise_cnt + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall_cnt <= '0;
    end else if (fall && !fall_full) begin
      fall_cnt <= fall_cnt + ONE;
    end
  end

endmodule

// File: rtl/nor3_x2.sv
// Three-input NOR cell, drive X2, with observation wrapper.
// Ports: A1..A3 in, ZN = ~(A1|A2|A3); clk, rst, ZN_q,
//   rise_cnt, fall_cnt, cnt_sat from activity_mon.
`timescale 1ns/1ps
module nor3_x2
  import nor3_x2_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             A1,
  input  logic             A2,
  input  logic             A3,
  output logic             ZN,
  input  logic             clk,
  input  logic             rst,
  output logic             ZN_q,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             cnt_sat
);

  // A dominant 1 on any input masks X/Z on the others.
  assign ZN = ~(A1 | A2 | A3);

  activity_mon #(
    .CNT_W (CNT_W)
  ) u_mon (
    .clk      (clk),
    .rst      (rst),
    .zn       (ZN),
    .zn_q     (ZN_q),
    .rise_cnt (rise_cnt),
    .fall_cnt (fall_cnt),
    .cnt_sat  (cnt_sat)
  );

endmodule

// File: tb/tb_nor3_x2.sv
// Self-checking bench for nor3_x2 (default and CNT_W=2).
// Directed steps followed by randomized cycles vs a model.
`timescale 1ns/1ps
module tb_nor3_x2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a1 = 1'b0;
  logic a2 = 1'b0;
  logic a3 = 1'b0;
  logic clk_nc = 1'bz;
  logic rst_nc = 1'bz;

  logic        zn0, zq0, sat0;
  logic [15:0] rc0, fc0;
  logic        zn1, zq1, sat1;
  logic [1:0]  rc1, fc1;
  logic        znf, zqf, satf;
  logic [15:0] rcf, fcf;

  int checks = 0;
  int errors = 0;

  // model state: index 0 = CNT_W 16, index 1 = CNT_W 2
  int  m_max [2] = '{65535, 3};
  int  m_rise [2];
  int  m_fall [2];
  logic m_prev;
  logic m_zq;

  always #5 clk = ~clk;

  nor3_x2 dut (
    .A1(a1), .A2(a2), .A3(a3), .ZN(zn0),
    .clk(clk), .rst(rst), .ZN_q(zq0),
    .rise_cnt(rc0), .fall_cnt(fc0), .cnt_sat(sat0)
  );

  nor3_x2 #(.CNT_W(2)) dut2 (
    .A1(a1), .A2(a2), .A3(a3), .ZN(zn1),
    .clk(clk), .rst(rst), .ZN_q(zq1),
    .rise_cnt(rc1), .fall_cnt(fc1), .cnt_sat(sat1)
  );

  nor3_x2 u_free (
    .A1(a1), .A2(a2), .A3(a3), .ZN(znf),
    .clk(clk_nc), .rst(rst_nc), .ZN_q(zqf),
    .rise_cnt(rcf), .fall_cnt(fcf), .cnt_sat(satf)
  );

  function automatic logic exp_zn();
    if (a1 === 1'b1 || a2 === 1'b1 || a3 === 1'b1)
      return 1'b0;
    if ($isunknown({a1, a2, a3}))
      return 1'bx;
    return 1'b1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b1;
    m_zq = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic z;
    z = exp_zn();
    for (int i = 0; i < 2; i++) begin
      if (z && !m_prev && m_rise[i] < m_max[i])
        m_rise[i]++;
      if (!z && m_prev && m_fall[i] < m_max[i])
        m_fall[i]++;
    end
    m_prev = z;
    m_zq = z;
  endtask

  task automatic chk_state(input string tag);
    logic s0, s1;
    s0 = (m_rise[0] == m_max[0]) || (m_fall[0] == m_max[0]);
    s1 = (m_rise[1] == m_max[1]) || (m_fall[1] == m_max[1]);
    chk({tag, ".zq"}, 32'(zq0), 32'(m_zq));
    chk({tag, ".rise"}, 32'(rc0), 32'(m_rise[0]));
    chk({tag, ".fall"}, 32'(fc0), 32'(m_fall[0]));
    chk({tag, ".sat"}, 32'(sat0), 32'(s0));
    chk({tag, ".zq2"}, 32'(zq1), 32'(m_zq));
    chk({tag, ".rise2"}, 32'(rc1), 32'(m_rise[1]));
    chk({tag, ".fall2"}, 32'(fc1), 32'(m_fall[1]));
    chk({tag, ".sat2"}, 32'(sat1), 32'(s1));
  endtask

  task automatic cyc(input string tag, input logic [2:0] v);
    @(negedge clk);
    {a1, a2, a3} = v;
    #1;
    chk({tag, ".zn"}, 32'(zn0), 32'(exp_zn()));
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    chk_state(tag);
  endtask

  task automatic release_rst();
    @(negedge clk);
    {a1, a2, a3} = 3'b000;
    rst = 1'b0;
  endtask

  task automatic async_rst(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_state(tag);
    {a1, a2, a3} = 3'($urandom_range(0, 7));
    #1;
    chk({tag, ".zn"}, 32'(zn0), 32'(exp_zn()));
  endtask

  initial begin
    model_reset();

    // walk truth table on the unclocked instance
    for (int v = 0; v < 8; v++) begin
      {a1, a2, a3} = 3'(v);
      #10;
      chk("walk", 32'(znf), 32'(v == 0));
    end

    {a1, a2, a3} = 3'b000;
    #1;
    chk_state("reset");

    // X handling while held in reset
    a1 = 1'b1; a2 = 1'bx; a3 = 1'b0;
    #1;
    chk("x_dom", 32'(zn0), 32'(1'b0));
    a1 = 1'b0;
    #1;
    chk("x_prop", 32'(zn0), 32'(exp_zn()));
    a2 = 1'b0;

    // first edge after reset with 100
    release_rst();
    cyc("first", 3'b100);
    chk("first.fall_k", 32'(fc0), 32'd1);
    chk("first.rise_k", 32'(rc0), 32'd0);

    // alternating toggle from 000
    async_rst("arst1");
    release_rst();
    for (int i = 0; i < 10; i++)
      cyc("tog", (i % 2 == 0) ? 3'b001 : 3'b000);
    chk("tog.rise_k", 32'(rc0), 32'd5);
    chk("tog.fall_k", 32'(fc0), 32'd5);
    chk("tog.sat2_k", 32'(sat1), 32'd1);

    // saturation on the narrow instance
    async_rst("arst2");
    release_rst();
    for (int i = 0; i < 8; i++)
      cyc("sat", (i % 2 == 0) ? 3'b010 : 3'b000);
    chk("sat.rise_k", 32'(rc1), 32'd3);
    chk("sat.fall_k", 32'(fc1), 32'd3);

    // async reset with nonzero counters
    async_rst("arst3");
    release_rst();

    // randomized run
    for (int i = 0; i < 400; i++) begin
      logic [2:0] v;
      v = ($urandom_range(0, 1) == 1) ? 3'b000
                                      : 3'($urandom_range(0, 7));
      cyc("rnd", v);
      if ($urandom_range(0, 99) == 0) begin
        async_rst("rnd_rst");
        release_rst();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
